mul_hilo_stage: RTL and testbench

Sequencing stage wrapped around the combinational 32×32 Booth pair multiplier. It accepts a multiply request with a start/ready handshake and registers the operands. It holds them stable while the product settles, then captures the 64-bit signed product into the architectural HI/LO registers. The CPU control unit drives it for MUL and reads its HI/LO outputs for MFHI/MFLO. It also services MTHI/MTLO writes.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/booth_pair_mul.sv | 59 +++++
 rtl/mul_hilo_stage.sv | 111 +++++++++++
 tb/tb_mul_hilo_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg: word width, sequencer state encoding and product type shared
// by the multiply and divide stages.                        Revision: 1.0
// ============================================================================
package muldiv_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    typedef logic [2*WORD_W-1:0] product_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/booth_pair_mul.sv
`default_nettype none
// ============================================================================
// booth_pair_mul: combinational signed multiplier, radix-4 Booth recoding of
// the multiplier (one digit per bit pair), exact 2*WIDTH result. Revision: 1.0
// ============================================================================
module booth_pair_mul #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product
);

    localparam int C_NDIG = (WIDTH + 1) / 2;
    localparam int C_PW   = 2 * WIDTH;

    // Multiplier bit with an implicit 0 below bit 0 and sign extension above.
    function automatic logic mbit(input logic [WIDTH-1:0] b, input int idx);
        logic r;
        if (idx < 0) begin
            r = 1'b0;
        end else if (idx >= WIDTH) begin
            r = b[WIDTH-1];
        end else begin
            r = b[idx];
        end
        return r;
    endfunction

    logic [C_PW-1:0] w_a_ext;
    logic [C_PW-1:0] w_a_x2;
    logic [C_PW-1:0] w_pp;
    logic [C_PW-1:0] w_acc;
    logic [2:0]      w_trip;

    assign w_a_ext = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
    assign w_a_x2  = w_a_ext << 1;

    always_comb begin
        w_acc  = '0;
        w_pp   = '0;
        w_trip = 3'b000;
        for (int i = 0; i < C_NDIG; i++) begin
            w_trip = {mbit(multiplier, 2*i + 1), mbit(multiplier, 2*i), mbit(multiplier, 2*i - 1)};
            case (w_trip)
                3'b001, 3'b010: w_pp = w_a_ext;
                3'b011:         w_pp = w_a_x2;
                3'b100:         w_pp = -w_a_x2;
                3'b101, 3'b110: w_pp = -w_a_ext;
                default:        w_pp = '0;
            endcase
            w_acc = w_acc + (w_pp << (2*i));
        end
    end

    assign product = w_acc;

endmodule : booth_pair_mul
`default_nettype wire

// File: rtl/mul_hilo_stage.sv
`default_nettype none
// ============================================================================
// mul_hilo_stage: start/ready sequencer around booth_pair_mul that captures
// the signed product into HI/LO and services MTHI/MTLO.      Revision: 1.0
// ============================================================================
module mul_hilo_stage
    import muldiv_pkg::*;
#(
    parameter int WIDTH         = WORD_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int               C_CNT_W    = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(SETTLE_CYCLES - 1);

    muldiv_state_e        state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [2*WIDTH-1:0]   w_product;

    // Operand registers feed the multiplier directly so the product stays stable during CALC.
    booth_pair_mul #(
        .WIDTH (WIDTH)
    ) u_booth_pair_mul (
        .multiplicand (a_q),
        .multiplier   (b_q),
        .product      (w_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (hi_wr) begin
                    hi_d = wr_data;
                end
                if (lo_wr) begin
                    lo_d = wr_data;
                end
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_CNT_LAST) begin
                    hi_d    = w_product[2*WIDTH-1:WIDTH];
                    lo_d    = w_product[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready  = (state_q == IDLE);
    assign busy   = (state_q == CALC) || (state_q == DONE);
    assign done   = (state_q == DONE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule : mul_hilo_stage
`default_nettype wire

// File: tb/tb_mul_hilo_stage.sv
`default_nettype none
// ============================================================================
// tb_mul_hilo_stage: scoreboard bench driving a SETTLE_CYCLES=1 and a
// SETTLE_CYCLES=3 instance with directed multiplies and HI/LO writes.
// ============================================================================
module tb_mul_hilo_stage;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n   [2];
    logic        start   [2];
    logic        ready   [2];
    logic [31:0] op_a    [2];
    logic [31:0] op_b    [2];
    logic        busy    [2];
    logic        done    [2];
    logic        hi_wr   [2];
    logic        lo_wr   [2];
    logic [31:0] wr_data [2];
    logic [31:0] hi_out  [2];
    logic [31:0] lo_out  [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    mul_hilo_stage #(.WIDTH(32), .SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .ready(ready[0]),
        .op_a(op_a[0]), .op_b(op_b[0]), .busy(busy[0]), .done(done[0]),
        .hi_wr(hi_wr[0]), .lo_wr(lo_wr[0]), .wr_data(wr_data[0]),
        .hi_out(hi_out[0]), .lo_out(lo_out[0])
    );

    mul_hilo_stage #(.WIDTH(32), .SETTLE_CYCLES(3)) u_dut_s3 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .ready(ready[1]),
        .op_a(op_a[1]), .op_b(op_b[1]), .busy(busy[1]), .done(done[1]),
        .hi_wr(hi_wr[1]), .lo_wr(lo_wr[1]), .wr_data(wr_data[1]),
        .hi_out(hi_out[1]), .lo_out(lo_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_exp(input int d, input logic [63:0] prod, input int c);
        exp_t e;
        e.hi  = prod[63:32];
        e.lo  = prod[31:0];
        e.cyc = c;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (done[d] === 1'b1) begin
                exp_t e;
                int   have;
                have = (d == 0) ? q0.size() : q1.size();
                if (have == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done dut%0d at cycle %0d", d, cyc);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("dut%0d_hi", d), hi_out[d], e.hi);
                    chk($sformatf("dut%0d_lo", d), lo_out[d], e.lo);
                    chk($sformatf("dut%0d_done_cycle", d), cyc, e.cyc);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with ready high, or counts a failure.
    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (ready[d] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (ready[d] !== 1'b1) begin
            n_total++;
            $display("FAIL ready_timeout dut%0d: got ready=%b, expected 1 within 50 cycles", d, ready[d]);
        end
    endtask

    task automatic do_mul(input int d, input int s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] prod, input bit scramble);
        int k;
        wait_idle(d);
        op_a[d]  = a;
        op_b[d]  = b;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        k = cyc;
        push_exp(d, prod, k + s);
        if (scramble) begin
            op_a[d] = ~a;
            op_b[d] = a ^ b;
        end
        for (int i = 1; i <= s + 1; i++) begin
            @(posedge clk); #1;
            chk($sformatf("dut%0d_ready_busy_e%0d", d, i), {62'd0, ready[d], busy[d]},
                (i <= s) ? 64'd1 : 64'd2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int k;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; start[d] = 1'b0; hi_wr[d] = 1'b0; lo_wr[d] = 1'b0;
            op_a[d] = '0; op_b[d] = '0; wr_data[d] = '0;
        end
        #1;
        chk("reset_ready", {63'd0, ready[0]}, 64'd1);
        chk("reset_busy",  {63'd0, busy[0]},  64'd0);
        chk("reset_done",  {63'd0, done[0]},  64'd0);
        chk("reset_hilo",  {hi_out[0], lo_out[0]}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // SETTLE_CYCLES=1 products
        do_mul(0, 1, 32'd15,        32'd3,        64'h0000_0000_0000_002D, 1'b0);
        do_mul(0, 1, 32'hFFFF_FFF9, 32'd5,        64'hFFFF_FFFF_FFFF_FFDD, 1'b1);
        do_mul(0, 1, 32'hFFFF_FFF4, 32'hFFFF_FFFC, 64'h0000_0000_0000_0030, 1'b0);
        do_mul(0, 1, 32'd0,         32'd123,      64'h0000_0000_0000_0000, 1'b0);
        do_mul(0, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);

        // start held high: one multiply, the next accepted only on return to IDLE
        wait_idle(0);
        op_a[0] = 32'd2; op_b[0] = 32'd5; start[0] = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        push_exp(0, 64'd10, k + 1);
        push_exp(0, 64'd15, k + 4);
        op_a[0] = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        start[0] = 1'b0;
        chk("held_start_second_accept", {63'd0, ready[0]}, 64'd0);
        wait_idle(0);

        // MTHI / MTLO in IDLE
        hi_wr[0] = 1'b1; wr_data[0] = 32'h1234;
        @(posedge clk); #1;
        hi_wr[0] = 1'b0;
        chk("mthi_idle_hi", hi_out[0], 64'h1234);
        chk("mthi_idle_lo", lo_out[0], 64'h000F);
        hi_wr[0] = 1'b1; lo_wr[0] = 1'b1; wr_data[0] = 32'hABCD;
        @(posedge clk); #1;
        hi_wr[0] = 1'b0; lo_wr[0] = 1'b0;
        chk("mthi_mtlo_both", {hi_out[0], lo_out[0]}, 64'h0000ABCD_0000ABCD);

        // start together with MTHI: write lands now, product overwrites at capture
        op_a[0] = 32'd2; op_b[0] = 32'd3; start[0] = 1'b1;
        hi_wr[0] = 1'b1; wr_data[0] = 32'h5555;
        @(posedge clk); #1;
        k = cyc;
        start[0] = 1'b0; hi_wr[0] = 1'b0;
        push_exp(0, 64'd6, k + 1);
        chk("start_mthi_hi_now", hi_out[0], 64'h5555);
        wait_idle(0);

        // SETTLE_CYCLES=3: -15732481 * -61456 = 966855352336, operands scrambled during CALC
        do_mul(1, 3, 32'hFF0F_F0FF, 32'hFFFF_0FF0, 64'h0000_00E1_1D11_E010, 1'b1);

        // MTHI held through CALC and DONE is ignored
        wait_idle(1);
        op_a[1] = 32'hFFFF_FFF9; op_b[1] = 32'd5; start[1] = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        start[1] = 1'b0;
        push_exp(1, 64'hFFFF_FFFF_FFFF_FFDD, k + 3);
        hi_wr[1] = 1'b1; wr_data[1] = 32'h1234;
        @(posedge clk); #1;
        chk("mthi_calc_ignored", hi_out[1], 64'h0000_00E1);
        repeat (3) @(posedge clk);
        #1;
        hi_wr[1] = 1'b0;
        chk("mthi_done_ignored", hi_out[1], 64'hFFFF_FFFF);
        wait_idle(1);

        // asynchronous reset in the middle of CALC
        op_a[1] = 32'd7; op_b[1] = 32'd9; start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        @(posedge clk); #3;
        rst_n[1] = 1'b0;
        #1;
        chk("async_rst_hilo",  {hi_out[1], lo_out[1]}, 64'd0);
        chk("async_rst_ready", {63'd0, ready[1]}, 64'd1);
        chk("async_rst_busy",  {63'd0, busy[1]},  64'd0);
        chk("async_rst_done",  {63'd0, done[1]},  64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        do_mul(1, 3, 32'd2, 32'd3, 64'd6, 1'b0);

        wait_idle(0);
        wait_idle(1);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard0_drained", q0.size(), 64'd0);
        chk("scoreboard1_drained", q1.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mul_hilo_stage
`default_nettype wire
